// File: rtl/link_arq_ctrl.sv
// Stop-and-wait ARQ sequencer for one encoder/decoder link; optional LINK_ARQ_FLUSH_EN drops held decoder packets before launch.
// Latency >= 5 cycles accept-to-done; tx_ready only in IDLE, start_ENC waits on avail_ENC, replies are popped only in LISTEN.
module link_arq_ctrl #(
  parameter int N_PKT     = 8,
  parameter int TIMEOUT   = 1465,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [N_PKT-1:0] tx_data,
  input  logic [N_PKT-1:0] tx_expected,
  output logic             tx_ready,
  output logic             start_ENC,
  output logic [N_PKT-1:0] data_ENC,
  input  logic             avail_ENC,
  input  logic [N_PKT-1:0] data_DEC,
  input  logic             avail_DEC,
  input  logic             error_DEC,
  output logic             read_DEC,
  output logic             done,
  output logic             fail,
  output logic [N_PKT-1:0] rx_data,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ATT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_TX_BUSY,
    S_LISTEN,
    S_CHECK,
    S_RETRY
  } state_t;

  state_t             state_q, state_d;
  logic [N_PKT-1:0]   pkt_q, pkt_d;
  logic [N_PKT-1:0]   exp_q, exp_d;
  logic [N_PKT-1:0]   cap_dat_q, cap_dat_d;
  logic               cap_err_q, cap_err_d;
  logic [N_PKT-1:0]   rx_q, rx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic               seen_low_q, seen_low_d;
  logic [CNT_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic launch_go;
  logic flush_rd;
  logic tmr_exp;
  logic match;
  logic can_retry;

  assign tmr_exp   = (timer_q == TMR_W'(TIMEOUT - 1));
  assign match     = !cap_err_q && (cap_dat_q == exp_q);
  assign can_retry = (att_q < ATT_W'(MAX_RETRY));

`ifdef LINK_ARQ_FLUSH_EN
  // A gap cycle after each pop lets the decoder update avail_DEC, so one
  // held packet is never popped twice.
  logic flush_gap_q, flush_gap_d;

  assign flush_rd    = (state_q == S_LAUNCH) && avail_DEC && !flush_gap_q;
  assign launch_go   = avail_ENC && !avail_DEC && !flush_gap_q;
  assign flush_gap_d = flush_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_gap_q <= 1'b0;
    end else begin
      flush_gap_q <= flush_gap_d;
    end
  end
`else
  assign flush_rd  = 1'b0;
  assign launch_go = avail_ENC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tx_valid) state_d = S_LAUNCH;
      S_LAUNCH:  if (launch_go) state_d = S_TX_BUSY;
      S_TX_BUSY: if (seen_low_q && avail_ENC) state_d = S_LISTEN;
      S_LISTEN: begin
        // A reply arriving on the expiry cycle still wins over the timeout.
        if (avail_DEC)    state_d = S_CHECK;
        else if (tmr_exp) state_d = S_RETRY;
      end
      S_CHECK:   state_d = match ? S_IDLE : S_RETRY;
      S_RETRY:   state_d = can_retry ? S_LAUNCH : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready  = (state_q == S_IDLE);
    start_ENC = (state_q == S_LAUNCH) && launch_go;
    read_DEC  = ((state_q == S_LISTEN) && avail_DEC) || flush_rd;
    done      = (state_q == S_CHECK) && match;
    fail      = (state_q == S_RETRY) && !can_retry;
  end

  always_comb begin
    pkt_d       = pkt_q;
    exp_d       = exp_q;
    cap_dat_d   = cap_dat_q;
    cap_err_d   = cap_err_q;
    rx_d        = rx_q;
    timer_d     = timer_q;
    att_d       = att_q;
    seen_low_d  = seen_low_q;
    retry_cnt_d = retry_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          pkt_d = tx_data;
          exp_d = tx_expected;
          att_d = '0;
        end
      end
      S_LAUNCH: begin
        seen_low_d = 1'b0;
      end
      S_TX_BUSY: begin
        // The encoder must be seen busy before its idle counts as finished.
        if (!avail_ENC) seen_low_d = 1'b1;
        timer_d = '0;
      end
      S_LISTEN: begin
        timer_d = timer_q + TMR_W'(1);
        if (avail_DEC) begin
          cap_dat_d = data_DEC;
          cap_err_d = error_DEC;
        end
      end
      S_CHECK: begin
        if (match) begin
          rx_d = cap_dat_q;
        end else if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
      S_RETRY: begin
        if (can_retry) begin
          att_d = att_q + ATT_W'(1);
          if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q       <= '0;
      exp_q       <= '0;
      cap_dat_q   <= '0;
      cap_err_q   <= 1'b0;
      rx_q        <= '0;
      timer_q     <= '0;
      att_q       <= '0;
      seen_low_q  <= 1'b0;
      retry_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      pkt_q       <= pkt_d;
      exp_q       <= exp_d;
      cap_dat_q   <= cap_dat_d;
      cap_err_q   <= cap_err_d;
      rx_q        <= rx_d;
      timer_q     <= timer_d;
      att_q       <= att_d;
      seen_low_q  <= seen_low_d;
      retry_cnt_q <= retry_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_ENC  = pkt_q;
  assign rx_data   = rx_q;
  assign retry_cnt = retry_cnt_q;
  assign err_cnt   = err_cnt_q;

  a_done_fail_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done && fail));
  a_start_needs_enc: assert property (@(posedge clk) disable iff (!rst_n) start_ENC |-> avail_ENC);
  a_read_needs_dec: assert property (@(posedge clk) disable iff (!rst_n) read_DEC |-> avail_DEC);

endmodule

// File: tb/tb_link_arq_ctrl.sv
// Directed bench for link_arq_ctrl with a behavioural encoder/decoder pair and per-attempt reply table.
module tb_link_arq_ctrl;

  localparam int N  = 8;
  localparam int T  = 1465;
  localparam int MR = 3;
  localparam int CW = 16;
  localparam int B  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_valid = 1'b0;
  logic [N-1:0]  tx_data = '0;
  logic [N-1:0]  tx_expected = '0;
  logic          tx_ready;
  logic          start_ENC;
  logic [N-1:0]  data_ENC;
  logic          avail_ENC = 1'b1;
  logic [N-1:0]  data_DEC = '0;
  logic          avail_DEC = 1'b0;
  logic          error_DEC = 1'b0;
  logic          read_DEC;
  logic          done;
  logic          fail;
  logic [N-1:0]  rx_data;
  logic [CW-1:0] retry_cnt;
  logic [CW-1:0] err_cnt;

  link_arq_ctrl #(.N_PKT(N), .TIMEOUT(T), .MAX_RETRY(MR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_expected(tx_expected), .tx_ready(tx_ready),
    .start_ENC(start_ENC), .data_ENC(data_ENC), .avail_ENC(avail_ENC),
    .data_DEC(data_DEC), .avail_DEC(avail_DEC), .error_DEC(error_DEC), .read_DEC(read_DEC),
    .done(done), .fail(fail), .rx_data(rx_data), .retry_cnt(retry_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int       n_start, n_read, n_done, n_fail, n_both;
  int       start_t [8];
  logic [N-1:0] start_dat [8];
  int       done_t, fail_t;
  int       enc_busy, rep_cnt, cur_att;
  bit       pend;
  bit       rep_en [4];
  logic [N-1:0] rep_dat [4];
  bit       rep_err [4];
  int       rep_dly [4];

  task automatic model_clear();
    n_start = 0; n_read = 0; n_done = 0; n_fail = 0;
    done_t = 0; fail_t = 0; enc_busy = 0; rep_cnt = 0; cur_att = 0; pend = 0;
    for (int i = 0; i < 4; i++) begin
      rep_en[i] = 0; rep_dat[i] = '0; rep_err[i] = 0; rep_dly[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      start_t[i] = 0; start_dat[i] = '0;
    end
    avail_ENC = 1'b1; avail_DEC = 1'b0; data_DEC = '0; error_DEC = 1'b0;
  endtask

  task automatic model_loop();
    bit o_st, o_rd;
    forever begin
      @(negedge clk);
      o_st = start_ENC;
      o_rd = read_DEC;
      if (start_ENC) begin
        if (n_start < 8) begin
          start_t[n_start] = cyc;
          start_dat[n_start] = data_ENC;
        end
        n_start++;
      end
      if (read_DEC) n_read++;
      if (done) begin n_done++; done_t = cyc; end
      if (fail) begin n_fail++; fail_t = cyc; end
      if (done && fail) n_both++;
      @(posedge clk); #1;
      if (o_rd) avail_DEC = 1'b0;
      if (o_st) begin
        avail_ENC = 1'b0;
        enc_busy = B;
      end else if (enc_busy > 0) begin
        enc_busy--;
        if (enc_busy == 0) begin
          avail_ENC = 1'b1;
          cur_att = n_start - 1;
          if (cur_att >= 0 && cur_att < 4 && rep_en[cur_att]) begin
            pend = 1;
            rep_cnt = rep_dly[cur_att];
          end
        end
      end
      if (pend) begin
        if (rep_cnt == 0) begin
          avail_DEC = 1'b1;
          data_DEC = rep_dat[cur_att];
          error_DEC = rep_err[cur_att];
          pend = 0;
        end else begin
          rep_cnt--;
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic [N-1:0] e, output bit ok);
    ok = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = d; tx_expected = e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = '1; tx_expected = '1;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    int base;
    base = n_done + n_fail;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (n_done + n_fail != base) begin ok = 1; break; end
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b exp 1", tx_ready); end
    checks++; if (start_ENC !== 1'b0) begin errors++; $display("FAIL rst_start_ENC got %b exp 0", start_ENC); end
    checks++; if (data_ENC !== 8'h00) begin errors++; $display("FAIL rst_data_ENC got %h exp 00", data_ENC); end
    checks++; if (read_DEC !== 1'b0) begin errors++; $display("FAIL rst_read_DEC got %b exp 0", read_DEC); end
    checks++; if (done !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL rst_done_fail got %b%b exp 00", done, fail); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", rx_data); end
    checks++; if (retry_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", retry_cnt, err_cnt); end
  endtask

  task automatic test_echo();
    bit ok, fin;
    apply_reset();
    rep_en[0] = 1; rep_dat[0] = 8'h5A; rep_dly[0] = 100;
    send(8'hA5, 8'h5A, ok);
    checks++; if (!ok) begin errors++; $display("FAIL echo_accept got 0 exp 1"); end
    @(negedge clk);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL echo_busy_ready got %b exp 0", tx_ready); end
    wait_end(500, fin);
    checks++; if (!fin) begin errors++; $display("FAIL echo_timeout got none exp done"); end
    checks++; if (n_done !== 1 || n_fail !== 0) begin errors++; $display("FAIL echo_pulses got done=%0d fail=%0d exp 1/0", n_done, n_fail); end
    checks++; if (n_start !== 1 || n_read !== 1) begin errors++; $display("FAIL echo_strobes got start=%0d read=%0d exp 1/1", n_start, n_read); end
    checks++; if (start_dat[0] !== 8'hA5) begin errors++; $display("FAIL echo_data_ENC got %h exp a5", start_dat[0]); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL echo_rx_data got %h exp 5a", rx_data); end
    checks++; if (retry_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL echo_counters got %0d/%0d exp 0/0", retry_cnt, err_cnt); end
    checks++; if (done_t - start_t[0] !== B + 102) begin errors++; $display("FAIL echo_latency got %0d exp %0d", done_t - start_t[0], B + 102); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL echo_ready_after got %b exp 1", tx_ready); end
  endtask

  task automatic test_timeout_chain();
    bit ok, fin;
    apply_reset();
    send(8'h42, 8'h24, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_accept got 0 exp 1"); end
    wait_end(4 * (T + 20), fin);
    checks++; if (!fin) begin errors++; $display("FAIL tmo_wait got none exp fail"); end
    checks++; if (n_start !== MR + 1) begin errors++; $display("FAIL tmo_starts got %0d exp %0d", n_start, MR + 1); end
    for (int i = 0; i < MR; i++) begin
      checks++;
      if (start_t[i+1] - start_t[i] !== T + B + 3) begin
        errors++; $display("FAIL tmo_interval%0d got %0d exp %0d", i, start_t[i+1] - start_t[i], T + B + 3);
      end
    end
    checks++; if (n_fail !== 1 || n_done !== 0) begin errors++; $display("FAIL tmo_pulses got fail=%0d done=%0d exp 1/0", n_fail, n_done); end
    checks++; if (fail_t - start_t[MR] !== T + B + 2) begin errors++; $display("FAIL tmo_fail_time got %0d exp %0d", fail_t - start_t[MR], T + B + 2); end
    checks++; if (retry_cnt !== 16'd3 || err_cnt !== 16'd0) begin errors++; $display("FAIL tmo_counters got %0d/%0d exp 3/0", retry_cnt, err_cnt); end
    checks++; if (n_read !== 0) begin errors++; $display("FAIL tmo_reads got %0d exp 0", n_read); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready got %b exp 1", tx_ready); end
  endtask

  task automatic test_error_then_good();
    bit ok, fin;
    apply_reset();
    rep_en[0] = 1; rep_dat[0] = 8'h3C; rep_err[0] = 1; rep_dly[0] = 10;
    rep_en[1] = 1; rep_dat[1] = 8'h3C; rep_err[1] = 0; rep_dly[1] = 10;
    send(8'h77, 8'h3C, ok);
    wait_end(500, fin);
    checks++; if (!ok || !fin || n_done !== 1 || n_fail !== 0) begin errors++; $display("FAIL errgood_pulses got done=%0d fail=%0d exp 1/0", n_done, n_fail); end
    checks++; if (err_cnt !== 16'd1 || retry_cnt !== 16'd1) begin errors++; $display("FAIL errgood_counters got err=%0d retry=%0d exp 1/1", err_cnt, retry_cnt); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL errgood_rx_data got %h exp 3c", rx_data); end
    checks++; if (n_start !== 2 || n_read !== 2) begin errors++; $display("FAIL errgood_strobes got start=%0d read=%0d exp 2/2", n_start, n_read); end
  endtask

  task automatic test_mismatch();
    bit ok, fin;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      rep_en[i] = 1; rep_dat[i] = 8'h11; rep_err[i] = 0; rep_dly[i] = 5;
    end
    send(8'h99, 8'h22, ok);
    wait_end(500, fin);
    checks++; if (!ok || !fin || n_fail !== 1 || n_done !== 0) begin errors++; $display("FAIL mis_pulses got fail=%0d done=%0d exp 1/0", n_fail, n_done); end
    checks++; if (err_cnt !== 16'd4 || retry_cnt !== 16'd3) begin errors++; $display("FAIL mis_counters got err=%0d retry=%0d exp 4/3", err_cnt, retry_cnt); end
    checks++; if (n_read !== 4 || n_start !== 4) begin errors++; $display("FAIL mis_strobes got read=%0d start=%0d exp 4/4", n_read, n_start); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mis_rx_data got %h exp 00", rx_data); end
  endtask

  task automatic test_race();
    bit ok, fin;
    apply_reset();
    rep_en[0] = 1; rep_dat[0] = 8'hC3; rep_dly[0] = T;
    send(8'h01, 8'hC3, ok);
    wait_end(T + 100, fin);
    checks++; if (!ok || !fin || n_done !== 1 || n_start !== 1) begin errors++; $display("FAIL race_win got done=%0d start=%0d exp 1/1", n_done, n_start); end
    checks++; if (retry_cnt !== 16'd0 || done_t - start_t[0] !== T + B + 2) begin errors++; $display("FAIL race_timing got retry=%0d lat=%0d exp 0/%0d", retry_cnt, done_t - start_t[0], T + B + 2); end

    // One cycle late: the timeout fires and the stale reply is judged next LISTEN.
    apply_reset();
    rep_en[0] = 1; rep_dat[0] = 8'hC3; rep_dly[0] = T + 1;
    send(8'h01, 8'hC3, ok);
    wait_end(2 * T + 100, fin);
    checks++; if (!ok || !fin || n_done !== 1 || n_start !== 2 || n_read !== 1) begin errors++; $display("FAIL late_stale got done=%0d start=%0d read=%0d exp 1/2/1", n_done, n_start, n_read); end
    checks++; if (retry_cnt !== 16'd1 || done_t - start_t[1] !== B + 3) begin errors++; $display("FAIL late_timing got retry=%0d lat=%0d exp 1/%0d", retry_cnt, done_t - start_t[1], B + 3); end
  endtask

  task automatic test_reset_midway();
    bit ok;
    apply_reset();
    rep_en[0] = 1; rep_dat[0] = 8'h66; rep_dly[0] = 5;
    send(8'h55, 8'h66, ok);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (n_start != 0) break;
    end
    checks++; if (n_start !== 1 || data_ENC !== 8'h55) begin errors++; $display("FAIL mid_launch got start=%0d data=%h exp 1/55", n_start, data_ENC); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_ready !== 1'b1 || start_ENC !== 1'b0 || read_DEC !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got ready=%b start=%b read=%b exp 1/0/0", tx_ready, start_ENC, read_DEC); end
    checks++; if (data_ENC !== 8'h00 || rx_data !== 8'h00 || done !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL mid_rst_data got enc=%h rx=%h d=%b f=%b exp 00/00/0/0", data_ENC, rx_data, done, fail); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #2;
    checks++; if (n_done !== 0 || n_fail !== 0) begin errors++; $display("FAIL mid_no_pulse got done=%0d fail=%0d exp 0/0", n_done, n_fail); end
    checks++; if (n_read !== 0 || tx_ready !== 1'b1) begin errors++; $display("FAIL mid_idle_noread got read=%0d ready=%b exp 0/1", n_read, tx_ready); end
  endtask

  initial begin
    n_both = 0;
    model_clear();
    fork
      model_loop();
      begin
        test_reset();
        test_echo();
        test_timeout_chain();
        test_error_then_good();
        test_mismatch();
        test_race();
        test_reset_midway();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL done_fail_overlap got %0d exp 0", n_both); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/link_arq_ctrl.md
Name: link_arq_ctrl

Overview:
Stop-and-wait ARQ controller that sequences one Encoder/Decoder pulse-link pair on behalf of a single client.
- Accepts a packet from the client, launches the Encoder, then listens on the Decoder for a reply until a timeout.
- Compares the reply against the client-supplied expected value.
- Retransmits on timeout, decode error or mismatch, up to a retry limit, then reports success or failure.
- Sits between the player logic and the Encoder/Decoder, replacing ad-hoc start/read sequencing.

Parameters:
N_PKT, 8, packet width in bits
TIMEOUT, 1465, listen-window length in clk cycles, counted from the encoder going idle
MAX_RETRY, 3, retransmissions allowed after the first attempt (0 = single attempt)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tx_valid  in  1  client has a packet to exchange
tx_data  in  N_PKT  packet to send
tx_expected  in  N_PKT  reply value that counts as success
tx_ready  out  1  controller idle, request accepted this cycle if tx_valid
start_ENC  out  1  one-cycle encoder launch strobe
data_ENC  out  N_PKT  packet presented to encoder
avail_ENC  in  1  encoder idle/ready
data_DEC  in  N_PKT  decoded packet
avail_DEC  in  1  decoder holds a packet
error_DEC  in  1  held packet is corrupt (valid only with avail_DEC)
read_DEC  out  1  one-cycle decoder pop strobe
done  out  1  one-cycle pulse: exchange succeeded
fail  out  1  one-cycle pulse: retries exhausted
rx_data  out  N_PKT  last accepted reply, held until the next done
retry_cnt  out  CNT_W  total retransmissions since reset
err_cnt  out  CNT_W  total corrupt or mismatched replies since reset

Behaviour:
Reset values:
- All outputs are 0 except tx_ready, which is 1.
- State is IDLE and internal counters are cleared.
- Asserting rst_n mid-exchange aborts it immediately with no done or fail pulse.

Handshake:
- The request is accepted on a cycle where tx_valid && tx_ready.
- tx_data and tx_expected are registered at acceptance; later changes are ignored.
- tx_ready is 1 only in IDLE.

States:
- IDLE: tx_ready=1. On acceptance go to LAUNCH; attempt counter is set to 0.
- LAUNCH: wait for avail_ENC=1. Then drive start_ENC=1 for exactly one cycle with data_ENC = the registered packet, and go to TX_BUSY. data_ENC holds its value through TX_BUSY.
- TX_BUSY: wait until avail_ENC=0 has been seen at least once and avail_ENC has returned to 1, then go to LISTEN. The timer is loaded with 0.
- LISTEN: the timer increments every cycle.
  - If avail_DEC=1: assert read_DEC for one cycle and go to CHECK, capturing data_DEC and error_DEC.
  - Else if the timer reaches TIMEOUT-1: go to RETRY.
  - If avail_DEC rises on the same cycle the timer expires, the packet wins.
- CHECK:
  - If error_DEC=0 and the captured data equals tx_expected: rx_data <= captured, done=1 for one cycle, go to IDLE.
  - Otherwise increment err_cnt and go to RETRY.
- RETRY:
  - If attempt < MAX_RETRY: increment attempt and retry_cnt, go to LAUNCH.
  - Otherwise: fail=1 for one cycle, go to IDLE.

Additional rules:
- Decoder packets arriving outside LISTEN are not read.
- The first packet seen in the next LISTEN is consumed, so stale replies are read and judged.
- Counters saturate at all-ones and do not wrap.
- done and fail are never asserted together.
- Minimum latency, with encoder and decoder instantly responsive, is 5 cycles from acceptance to done: LAUNCH, TX_BUSY (≥2), LISTEN, CHECK.

Optional Feature:
LINK_ARQ_FLUSH_EN:
- When defined: on entry to LAUNCH, any packet held by the decoder (avail_DEC=1) is discarded. read_DEC is pulsed once per held packet, err_cnt is unchanged, and start_ENC waits until avail_DEC=0.
- When not defined: there is no flush, and stale packets are consumed in LISTEN as stated above.

Test Plan:
- Ideal echo: send 0xA5 expecting 0x5A; model replies 0x5A 100 cycles after the encoder goes idle -> one start_ENC, one read_DEC, done pulse, rx_data=0x5A, retry_cnt=0, err_cnt=0.
- Timeout chain: MAX_RETRY=3, no reply ever -> exactly 4 start_ENC strobes, each LISTEN lasting TIMEOUT cycles, then fail pulse; retry_cnt=3, tx_ready returns to 1.
- Error then good: first reply has error_DEC=1, second reply is correct 0x3C -> err_cnt=1, retry_cnt=1, done with rx_data=0x3C.
- Mismatch: reply 0x11 when expecting 0x22, on all attempts -> err_cnt=4, fail pulse, no done.
- Race and reset: avail_DEC rises exactly on timer expiry -> packet read, no retry. Separately, rst_n low during TX_BUSY -> all outputs return to reset values and no done/fail pulse occurs.
